// File: rtl/frame_dispatcher.sv
// frame_dispatcher: sequences one frame of triangles into the colour-fill loop.
// Each frame first commands a z-buffer clear. Triangles are then taken from an
// upstream valid/ready queue, their start row is clamped, and each one is handed
// to the loop (color_en). The loop's done is answered with all_done. Frame
// completion, triangle and cull counts, and sticky error flags are reported.
// Triangle3D is carried as a packed VER_W-bit vector (3 vertices x 3 coords x 16b).
// Color is carried as a packed RGB_W-bit vector.
module frame_dispatcher #(
    parameter logic [15:0] CHUNK_SIZE     = 16'd32,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 20,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned VER_W          = 144,
    parameter int unsigned RGB_W          = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    tri_valid,
    output logic                    tri_ready,
    input  logic [VER_W-1:0]        tri_ver,
    input  logic [RGB_W-1:0]        tri_rgb,
    input  logic signed [15:0]      tri_ystart,
    input  logic                    tri_last,
    input  logic                    cl_ready,
    input  logic                    cl_done,
    output logic                    new_frame,
    output logic                    color_en,
    output logic [15:0]             height,
    output logic [VER_W-1:0]        ver,
    output logic [RGB_W-1:0]        rgb_val,
    output logic                    all_done,
    output logic                    busy,
    output logic                    frame_done,
    output logic [CNT_W-1:0]        tri_count,
    output logic [CNT_W-1:0]        cull_count,
    output logic                    timeout_err,
    output logic                    overrun_err
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [16:0] CHUNK_EXT = {1'b0, CHUNK_SIZE};

    typedef enum logic [3:0] {
        StIdle,
        StClear,
        StHold,
        StWaitClear,
        StFetch,
        StCheck,
        StIssue,
        StWaitDone,
        StRelease,
        StFin
    } state_e;

    state_e state_q, state_d;

    logic [VER_W-1:0]  ver_q;
    logic [RGB_W-1:0]  rgb_q;
    logic [15:0]       ystart_q;
    logic              last_q;
    logic [15:0]       height_q;
    logic [CNT_W-1:0]  tri_count_q;
    logic [CNT_W-1:0]  cull_count_q;
    logic              timeout_q;
    logic              overrun_q;
    logic [WD_W-1:0]   wd_q;

    logic              accept;
    logic              culled;
    logic              wd_expired;
    logic signed [16:0] ys_ext;

    // Sign-extend so negative rows never compare as large unsigned values.
    assign ys_ext     = {ystart_q[15], ystart_q};
    assign culled     = (ys_ext >= CHUNK_EXT);
    assign wd_expired = (wd_q == WD_LAST);
    assign accept     = tri_ready && tri_valid;

    assign busy        = (state_q != StIdle);
    assign height      = height_q;
    assign ver         = ver_q;
    assign rgb_val     = rgb_q;
    assign tri_count   = tri_count_q;
    assign cull_count  = cull_count_q;
    assign timeout_err = timeout_q;
    assign overrun_err = overrun_q;

    // Next-state and pulse outputs, all decoded from the current state.
    always_comb begin
        state_d    = state_q;
        tri_ready  = 1'b0;
        new_frame  = 1'b0;
        color_en   = 1'b0;
        all_done   = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) state_d = StClear;
            end
            StClear: begin
                new_frame = 1'b1;
                state_d   = StHold;
            end
            // cl_ready may still reflect the loop state from before the clear.
            StHold: state_d = StWaitClear;
            StWaitClear: begin
                if (cl_ready) state_d = StFetch;
            end
            StFetch: begin
                tri_ready = 1'b1;
                if (tri_valid) state_d = StCheck;
            end
            StCheck: begin
                if (culled) state_d = last_q ? StFin : StFetch;
                else        state_d = StIssue;
            end
            StIssue: begin
                if (cl_ready) begin
                    color_en = 1'b1;
                    state_d  = StWaitDone;
                end
            end
            StWaitDone: begin
                if (cl_done)         state_d = StRelease;
                else if (wd_expired) state_d = StIdle;
            end
            StRelease: begin
                all_done = 1'b1;
                state_d  = last_q ? StFin : StFetch;
            end
            StFin: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Triangle latch and start-row clamp; held until the next accepted triangle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ver_q    <= '0;
            rgb_q    <= '0;
            ystart_q <= '0;
            last_q   <= 1'b0;
            height_q <= '0;
        end else begin
            if (accept) begin
                ver_q    <= tri_ver;
                rgb_q    <= tri_rgb;
                ystart_q <= tri_ystart;
                last_q   <= tri_last;
            end
            if (state_q == StCheck && !culled) begin
                height_q <= ystart_q[15] ? 16'd0 : ystart_q;
            end
        end
    end

    // Saturating frame counters and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_count_q  <= '0;
            cull_count_q <= '0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (frame_start) begin
                if (state_q == StIdle) begin
                    tri_count_q  <= '0;
                    cull_count_q <= '0;
                    timeout_q    <= 1'b0;
                    overrun_q    <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
            if (state_q == StCheck && culled && cull_count_q != '1) begin
                cull_count_q <= cull_count_q + CNT_W'(1);
            end
            if (color_en && tri_count_q != '1) begin
                tri_count_q <= tri_count_q + CNT_W'(1);
            end
            if (state_q == StWaitDone && !cl_done && wd_expired) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Watchdog on the loop's done; restarted each time a triangle is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (color_en) begin
            wd_q <= '0;
        end else if (state_q == StWaitDone && !cl_done && !wd_expired) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

endmodule

// File: tb/tb_frame_dispatcher.sv
// Scoreboard bench for frame_dispatcher: stimulus pushes expected issues and
// frame reports; a monitor pops and compares when the DUT presents them.
module tb_frame_dispatcher;

    localparam int VER_W = 144;
    localparam int RGB_W = 24;
    localparam int CNT_W = 16;

    typedef struct {
        logic [15:0]      h;
        logic [VER_W-1:0] v;
        logic [RGB_W-1:0] c;
    } issue_t;

    typedef struct {
        logic [CNT_W-1:0] tc;
        logic [CNT_W-1:0] cc;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, frame_start, tri_valid, tri_last, cl_ready, cl_done;
    logic [VER_W-1:0]   tri_ver;
    logic [RGB_W-1:0]   tri_rgb;
    logic signed [15:0] tri_ystart;
    logic               tri_ready, new_frame, color_en, all_done, busy, frame_done;
    logic [15:0]        height;
    logic [VER_W-1:0]   ver;
    logic [RGB_W-1:0]   rgb_val;
    logic [CNT_W-1:0]   tri_count, cull_count;
    logic               timeout_err, overrun_err;

    frame_dispatcher #(
        .CHUNK_SIZE     (16'd32),
        .TIMEOUT_CYCLES (64),
        .CNT_W          (CNT_W),
        .VER_W          (VER_W),
        .RGB_W          (RGB_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .tri_valid   (tri_valid),
        .tri_ready   (tri_ready),
        .tri_ver     (tri_ver),
        .tri_rgb     (tri_rgb),
        .tri_ystart  (tri_ystart),
        .tri_last    (tri_last),
        .cl_ready    (cl_ready),
        .cl_done     (cl_done),
        .new_frame   (new_frame),
        .color_en    (color_en),
        .height      (height),
        .ver         (ver),
        .rgb_val     (rgb_val),
        .all_done    (all_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .tri_count   (tri_count),
        .cull_count  (cull_count),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    int checks = 0;
    int errors = 0;
    int ce_cnt = 0, ad_cnt = 0, fd_cnt = 0, nf_cnt = 0;
    int fill_lat = 10;
    bit no_done = 1'b0;
    logic prev_cl_done = 1'b0;

    issue_t exp_issue[$];
    frame_t exp_frame[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VER_W-1:0] mk_ver(input logic [15:0] k);
        return {9{k}};
    endfunction

    // Monitor: samples one cycle's view just after the falling edge.
    initial begin
        issue_t e;
        frame_t f;
        forever begin
            @(negedge clk);
            #1;
            if (color_en) begin
                ce_cnt++;
                if (exp_issue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_color_en: got color_en=1, expected none");
                end else begin
                    e = exp_issue.pop_front();
                    chk("issue_height", height, e.h);
                    chk("issue_ver", ver, e.v);
                    chk("issue_rgb", rgb_val, e.c);
                end
            end
            if (all_done) begin
                ad_cnt++;
                chk("all_done_after_cl_done", prev_cl_done, 1'b1);
            end
            if (frame_done) begin
                fd_cnt++;
                if (exp_frame.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: got frame_done=1, expected none");
                end else begin
                    f = exp_frame.pop_front();
                    chk("frame_tri_count", tri_count, f.tc);
                    chk("frame_cull_count", cull_count, f.cc);
                end
            end
            if (new_frame) nf_cnt++;
            prev_cl_done = cl_done;
        end
    end

    // Colour-fill loop model: answers each color_en with cl_done after fill_lat cycles.
    initial begin
        cl_done = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (color_en && !no_done) begin
                repeat (fill_lat) @(negedge clk);
                cl_done = 1'b1;
                @(negedge clk);
                cl_done = 1'b0;
            end
        end
    end

    task automatic drive_tri(input logic [VER_W-1:0] v, input logic [RGB_W-1:0] c,
                             input logic signed [15:0] ys, input logic last);
        int n = 0;
        tri_ver    = v;
        tri_rgb    = c;
        tri_ystart = ys;
        tri_last   = last;
        tri_valid  = 1'b1;
        while (!tri_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tri_handshake", tri_ready, 1'b1);
        @(negedge clk);
        tri_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("frame_returns_idle", busy, 1'b0);
    endtask

    task automatic start_frame();
        int n = 0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        while (!tri_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("start_reaches_fetch", tri_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int ce0, ad0, fd0;
        bit bad, stable;
        rst = 1'b1; frame_start = 1'b0; tri_valid = 1'b0; tri_last = 1'b0;
        cl_ready = 1'b0; tri_ver = '0; tri_rgb = '0; tri_ystart = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_tri_ready", tri_ready, 1'b0);
        chk("reset_outputs", {height, ver, rgb_val, tri_count, cull_count,
                              timeout_err, overrun_err, new_frame, all_done, frame_done}, '0);

        // Clear sequence with cl_ready held low for 10 cycles.
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("clear_new_frame_high", new_frame, 1'b1);
        @(negedge clk);
        chk("clear_new_frame_one_cycle", new_frame, 1'b0);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tri_ready) bad = 1'b1;
        end
        chk("no_tri_ready_before_cl_ready", bad, 1'b0);
        cl_ready = 1'b1;
        @(negedge clk);
        chk("fetch_after_cl_ready", tri_ready, 1'b1);
        chk("new_frame_pulse_count", nf_cnt, 1);

        // Single triangle, loop done 40 cycles after issue.
        exp_issue.push_back('{h: 16'd5, v: mk_ver(16'h1111), c: 24'hAA0001});
        exp_frame.push_back('{tc: 16'd1, cc: 16'd0});
        fill_lat = 40;
        ad0 = ad_cnt; fd0 = fd_cnt;
        drive_tri(mk_ver(16'h1111), 24'hAA0001, 16'sd5, 1'b1);
        wait_idle();
        chk("single_all_done_count", ad_cnt - ad0, 1);
        chk("single_frame_done_count", fd_cnt - fd0, 1);
        chk("single_tri_count_held", tri_count, 16'd1);

        // Clamping: -3 -> 0, 31 -> 31, 32 culled as last.
        exp_issue.push_back('{h: 16'd0, v: mk_ver(16'h2222), c: 24'hBB0002});
        exp_issue.push_back('{h: 16'd31, v: mk_ver(16'h3333), c: 24'hCC0003});
        exp_frame.push_back('{tc: 16'd2, cc: 16'd1});
        fill_lat = 5;
        ce0 = ce_cnt; fd0 = fd_cnt;
        start_frame();
        chk("counters_zeroed_on_start", {tri_count, cull_count}, '0);
        drive_tri(mk_ver(16'h2222), 24'hBB0002, -16'sd3, 1'b0);
        drive_tri(mk_ver(16'h3333), 24'hCC0003, 16'sd31, 1'b0);
        drive_tri(mk_ver(16'h4444), 24'hDD0004, 16'sd32, 1'b1);
        wait_idle();
        chk("clamp_color_en_count", ce_cnt - ce0, 2);
        chk("clamp_frame_done_count", fd_cnt - fd0, 1);
        chk("clamp_cull_count", cull_count, 16'd1);

        // Backpressure upstream (tri_valid low) then downstream (cl_ready low).
        exp_issue.push_back('{h: 16'd10, v: mk_ver(16'h5555), c: 24'hEE0005});
        exp_frame.push_back('{tc: 16'd1, cc: 16'd0});
        start_frame();
        repeat (20) @(negedge clk);
        chk("bp_waits_in_fetch", {busy, tri_ready, tri_count}, {1'b1, 1'b1, 16'd0});
        cl_ready = 1'b0;
        drive_tri(mk_ver(16'h5555), 24'hEE0005, 16'sd10, 1'b1);
        ce0 = ce_cnt;
        @(negedge clk);
        stable = 1'b1;
        repeat (15) begin
            if (ver !== mk_ver(16'h5555) || rgb_val !== 24'hEE0005 || height !== 16'd10)
                stable = 1'b0;
            @(negedge clk);
        end
        chk("bp_no_color_en", ce_cnt - ce0, 0);
        chk("bp_outputs_stable", stable, 1'b1);
        cl_ready = 1'b1;
        wait_idle();
        chk("bp_issued_after_ready", ce_cnt - ce0, 1);

        // Timeout: loop never answers.
        no_done = 1'b1;
        exp_issue.push_back('{h: 16'd7, v: mk_ver(16'h6666), c: 24'h110006});
        start_frame();
        ad0 = ad_cnt; fd0 = fd_cnt;
        drive_tri(mk_ver(16'h6666), 24'h110006, 16'sd7, 1'b1);
        @(negedge clk);
        @(negedge clk);
        repeat (63) @(negedge clk);
        chk("timeout_not_early", {busy, timeout_err}, {1'b1, 1'b0});
        @(negedge clk);
        chk("timeout_err_set", timeout_err, 1'b1);
        chk("timeout_back_idle", busy, 1'b0);
        chk("timeout_no_all_done", ad_cnt - ad0, 0);
        chk("timeout_no_frame_done", fd_cnt - fd0, 0);

        // Next frame clears the flag; overrun mid-frame; reset during WAIT_DONE.
        no_done = 1'b0;
        fill_lat = 30;
        start_frame();
        chk("timeout_cleared_by_start", timeout_err, 1'b0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("overrun_err_set", overrun_err, 1'b1);
        chk("overrun_flow_unaffected", {busy, tri_ready}, {1'b1, 1'b1});
        exp_issue.push_back('{h: 16'd3, v: mk_ver(16'h7777), c: 24'h220007});
        drive_tri(mk_ver(16'h7777), 24'h220007, 16'sd3, 1'b0);
        repeat (3) @(negedge clk);
        chk("in_wait_done_before_reset", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_outputs", {height, ver, rgb_val, tri_count, cull_count, timeout_err,
                                  overrun_err, new_frame, color_en, all_done, frame_done,
                                  tri_ready}, '0);
        ad0 = ad_cnt; fd0 = fd_cnt;
        repeat (40) @(negedge clk);
        chk("reset_no_all_done", ad_cnt - ad0, 0);
        chk("reset_no_frame_done", fd_cnt - fd0, 0);
        chk("issue_queue_drained", exp_issue.size(), 0);
        chk("frame_queue_drained", exp_frame.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
